// File: rtl/preg_free_list_pkg.sv
// Shared sizing for the physical-register free list and a pointer helper
// that keeps ring arithmetic at tag width.
package preg_free_list_pkg;

    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 32;
    localparam int PREG_BITS = $clog2(NUM_PREGS);
    localparam int FREE_INIT = NUM_PREGS - NUM_AREGS;

    typedef logic [PREG_BITS-1:0] preg_t;
    typedef logic [PREG_BITS:0]   count_t;

    function automatic preg_t ptr_add(input preg_t ptr, input logic [1:0] n);
        return ptr + preg_t'(n);
    endfunction

endpackage

// File: rtl/preg_free_list_if.sv
// Rename-side and commit-side signals of the free list; the pipeline drives
// master, the free list itself sits on slave.
interface preg_free_list_if;
    import preg_free_list_pkg::*;

    logic       enabled;
    logic [1:0] alloc_req;
    logic       alloc_stall;
    preg_t      preg1;
    preg_t      preg2;
    logic [1:0] free_valid;
    preg_t      free_preg1;
    preg_t      free_preg2;
    logic [1:0] commit_count;
    logic       flush;
    count_t     free_count;
    logic       error;

    modport master (
        output enabled, alloc_req, free_valid, free_preg1, free_preg2,
               commit_count, flush,
        input  alloc_stall, preg1, preg2, free_count, error
    );

    modport slave (
        input  enabled, alloc_req, free_valid, free_preg1, free_preg2,
               commit_count, flush,
        output alloc_stall, preg1, preg2, free_count, error
    );

endinterface

// File: rtl/preg_free_list_ram.sv
// Tag storage for the free-list ring: two write ports, two asynchronous reads.
// Reset loads the tags that are not architecturally mapped (NUM_AREGS upward).
module free_list_ram
    import preg_free_list_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  we1,
    input  preg_t wr_addr1,
    input  preg_t wr_data1,
    input  logic  we2,
    input  preg_t wr_addr2,
    input  preg_t wr_data2,
    input  preg_t rd_addr1,
    input  preg_t rd_addr2,
    output preg_t rd_data1,
    output preg_t rd_data2
);

    preg_t mem [NUM_PREGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                mem[i] <= (i < FREE_INIT) ? preg_t'(NUM_AREGS + i) : '0;
            end
        end else begin
            if (we1) mem[wr_addr1] <= wr_data1;
            if (we2) mem[wr_addr2] <= wr_data2;
        end
    end

    assign rd_data1 = mem[rd_addr1];
    assign rd_data2 = mem[rd_addr2];

endmodule

// File: rtl/preg_free_list.sv
// Physical-register free list: hands out up to two tags per cycle, takes back
// up to two released tags, and rewinds to the committed head on flush.
module preg_free_list
    import preg_free_list_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    preg_free_list_if.slave bus
);

    preg_t                head;
    preg_t                tail;
    preg_t                commit_head;
    preg_t                in_flight;
    count_t               count;
    logic [PREG_BITS+1:0] count_sum;
    logic [1:0]           free_num;
    logic [1:0]           alloc_amt;
    logic                 alloc_stall;
    logic                 alloc_fire;
    logic                 count_err;
    logic                 commit_err;
    logic                 alloc_err;
    logic                 error_q;

    logic  we1;
    logic  we2;
    preg_t wr_addr1;
    preg_t wr_addr2;
    preg_t wr_data1;
    preg_t wr_data2;
    preg_t rd_data1;
    preg_t rd_data2;

    assign alloc_stall = count_t'(bus.alloc_req) > count;
    assign alloc_fire  = bus.enabled && !alloc_stall && !bus.flush;
    assign alloc_amt   = alloc_fire ? bus.alloc_req : 2'd0;
    assign free_num    = {1'b0, bus.free_valid[0]} + {1'b0, bus.free_valid[1]};

    // Compact the valid release tags so they always land at tail, tail+1.
    always_comb begin
        we1      = bus.free_valid != 2'b00;
        we2      = bus.free_valid == 2'b11;
        wr_addr1 = tail;
        wr_addr2 = ptr_add(tail, 2'd1);
        wr_data1 = bus.free_valid[0] ? bus.free_preg1 : bus.free_preg2;
        wr_data2 = bus.free_preg2;
    end

    // One extra bit of headroom so an underflow wraps high and trips the same check.
    assign count_sum  = {1'b0, count} + (PREG_BITS+2)'(free_num) - (PREG_BITS+2)'(alloc_amt);
    assign count_err  = !bus.flush && (count_sum > (PREG_BITS+2)'(FREE_INIT));
    assign in_flight  = head - commit_head;
    assign commit_err = preg_t'(bus.commit_count) > in_flight;
    assign alloc_err  = alloc_fire && (count_t'(bus.alloc_req) > count);

    free_list_ram u_ram (
        .clk      (clk),
        .reset    (reset),
        .we1      (we1),
        .wr_addr1 (wr_addr1),
        .wr_data1 (wr_data1),
        .we2      (we2),
        .wr_addr2 (wr_addr2),
        .wr_data2 (wr_data2),
        .rd_addr1 (head),
        .rd_addr2 (ptr_add(head, 2'd1)),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head        <= '0;
            commit_head <= '0;
            tail        <= preg_t'(FREE_INIT % NUM_PREGS);
            count       <= count_t'(FREE_INIT);
            error_q     <= 1'b0;
        end else begin
            commit_head <= ptr_add(commit_head, bus.commit_count);
            tail        <= ptr_add(tail, free_num);
            if (bus.flush) begin
                head  <= ptr_add(commit_head, bus.commit_count);
                count <= count_t'(FREE_INIT);
            end else begin
                if (alloc_fire) head <= ptr_add(head, bus.alloc_req);
                count <= count_sum[PREG_BITS:0];
            end
            if (count_err || commit_err || alloc_err) error_q <= 1'b1;
        end
    end

    assign bus.alloc_stall = alloc_stall;
    assign bus.preg1       = rd_data1;
    assign bus.preg2       = rd_data2;
    assign bus.free_count  = count;
    assign bus.error       = error_q;

endmodule

// File: tb/tb_preg_free_list.sv
// Directed scenarios for the free list followed by a randomized run checked
// against a queue-based model of free, speculative and architectural tags.
module tb_preg_free_list;
    import preg_free_list_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    preg_free_list_if bus ();

    preg_free_list dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    preg_t avail_q [$];
    preg_t spec_q  [$];
    preg_t arch_q  [$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] req, input logic [1:0] fv,
                                 input preg_t f1, input preg_t f2, input logic [1:0] cc,
                                 input logic fl);
        bus.enabled      = en;
        bus.alloc_req    = req;
        bus.free_valid   = fv;
        bus.free_preg1   = f1;
        bus.free_preg2   = f2;
        bus.commit_count = cc;
        bus.flush        = fl;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 2'd0, 2'b00, '0, '0, 2'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        idle();
        reset = 1'b0;
        #10;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        logic       en;
        logic       fl;
        logic       fire;
        logic [1:0] req;
        logic [1:0] fv;
        preg_t      f1;
        preg_t      f2;
        int         k;
        int         maxk;

        idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        tick();
        checkOutput("reset_preg1", 32'(bus.preg1), 32);
        checkOutput("reset_preg2", 32'(bus.preg2), 33);
        checkOutput("reset_count", 32'(bus.free_count), 32);
        checkOutput("reset_stall", 32'(bus.alloc_stall), 0);
        checkOutput("reset_error", 32'(bus.error), 0);

        // Drain the whole list two at a time, then prove the next request stalls.
        repeat (16) begin
            applyStimulus(1'b1, 2'd2, 2'b00, '0, '0, 2'd0, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 2'd1, 2'b00, '0, '0, 2'd0, 1'b0);
        #1;
        checkOutput("drain_count", 32'(bus.free_count), 0);
        checkOutput("drain_stall", 32'(bus.alloc_stall), 1);
        tick();
        checkOutput("stall_hold_count", 32'(bus.free_count), 0);
        checkOutput("stall_no_error", 32'(bus.error), 0);

        applyStimulus(1'b1, 2'd2, 2'b11, 6'd5, 6'd7, 2'd0, 1'b0);
        #1;
        checkOutput("free_empty_stall", 32'(bus.alloc_stall), 1);
        tick();
        applyStimulus(1'b0, 2'd2, 2'b00, '0, '0, 2'd0, 1'b0);
        #1;
        checkOutput("refill_preg1", 32'(bus.preg1), 5);
        checkOutput("refill_preg2", 32'(bus.preg2), 7);
        checkOutput("refill_count", 32'(bus.free_count), 2);
        checkOutput("refill_stall", 32'(bus.alloc_stall), 0);

        doReset();
        repeat (3) begin
            applyStimulus(1'b1, 2'd2, 2'b00, '0, '0, 2'd0, 1'b0);
            tick();
        end
        idle();
        #1;
        checkOutput("alloc6_count", 32'(bus.free_count), 26);
        checkOutput("alloc6_preg1", 32'(bus.preg1), 38);
        repeat (2) begin
            applyStimulus(1'b0, 2'd0, 2'b00, '0, '0, 2'd1, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 2'd0, 2'b00, '0, '0, 2'd0, 1'b1);
        tick();
        idle();
        #1;
        checkOutput("flush_count", 32'(bus.free_count), 32);
        checkOutput("flush_preg1", 32'(bus.preg1), 34);
        checkOutput("flush_preg2", 32'(bus.preg2), 35);
        checkOutput("flush_error", 32'(bus.error), 0);

        doReset();
        applyStimulus(1'b1, 2'd1, 2'b00, '0, '0, 2'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 2'b10, 6'd50, 6'd9, 2'd0, 1'b0);
        tick();
        idle();
        #1;
        checkOutput("free_hi_count", 32'(bus.free_count), 32);
        checkOutput("free_hi_error", 32'(bus.error), 0);
        applyStimulus(1'b0, 2'd0, 2'b01, 6'd11, 6'd60, 2'd0, 1'b0);
        tick();
        idle();
        #1;
        checkOutput("overflow_error", 32'(bus.error), 1);
        checkOutput("overflow_count", 32'(bus.free_count), 33);
        repeat (15) begin
            applyStimulus(1'b1, 2'd2, 2'b00, '0, '0, 2'd0, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 2'd1, 2'b00, '0, '0, 2'd0, 1'b0);
        tick();
        idle();
        #1;
        checkOutput("compact_preg1", 32'(bus.preg1), 9);
        checkOutput("compact_preg2", 32'(bus.preg2), 11);
        checkOutput("compact_count", 32'(bus.free_count), 2);
        checkOutput("sticky_error", 32'(bus.error), 1);

        doReset();
        applyStimulus(1'b0, 2'd0, 2'b00, '0, '0, 2'd1, 1'b0);
        tick();
        idle();
        #1;
        checkOutput("commit_past_head_error", 32'(bus.error), 1);

        // Reset dropped between edges while allocation is firing.
        doReset();
        applyStimulus(1'b1, 2'd2, 2'b00, '0, '0, 2'd0, 1'b0);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midreset_preg1", 32'(bus.preg1), 32);
        checkOutput("midreset_preg2", 32'(bus.preg2), 33);
        checkOutput("midreset_count", 32'(bus.free_count), 32);
        checkOutput("midreset_error", 32'(bus.error), 0);
        tick();
        checkOutput("midreset_hold_preg1", 32'(bus.preg1), 32);
        idle();
        reset = 1'b1;
        tick();
        checkOutput("postreset_preg1", 32'(bus.preg1), 32);
        checkOutput("postreset_count", 32'(bus.free_count), 32);

        // Randomized run: every commit releases one old architectural mapping.
        doReset();
        avail_q.delete();
        spec_q.delete();
        arch_q.delete();
        for (int i = 0; i < NUM_AREGS; i++) arch_q.push_back(preg_t'(i));
        for (int i = NUM_AREGS; i < NUM_PREGS; i++) avail_q.push_back(preg_t'(i));

        for (int c = 0; c < 400; c++) begin
            en   = ($urandom_range(0, 3) != 0);
            req  = 2'($urandom_range(0, 2));
            fl   = ($urandom_range(0, 19) == 0);
            maxk = (spec_q.size() < 2) ? spec_q.size() : 2;
            k    = int'($urandom_range(0, maxk));
            f1   = preg_t'($urandom);
            f2   = preg_t'($urandom);
            if (k == 2) begin
                fv = 2'b11;
                f1 = arch_q[0];
                f2 = arch_q[1];
            end else if (k == 1) begin
                fv = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
                if (fv == 2'b01) f1 = arch_q[0];
                else             f2 = arch_q[0];
            end else begin
                fv = 2'b00;
            end
            applyStimulus(en, req, fv, f1, f2, 2'(k), fl);
            #1;
            checkOutput("rand_stall", 32'(bus.alloc_stall), 32'(int'(req) > avail_q.size()));
            checkOutput("rand_count", 32'(bus.free_count), 32'(avail_q.size()));
            checkOutput("rand_error", 32'(bus.error), 0);
            if (avail_q.size() >= 1) checkOutput("rand_preg1", 32'(bus.preg1), 32'(avail_q[0]));
            if (avail_q.size() >= 2) checkOutput("rand_preg2", 32'(bus.preg2), 32'(avail_q[1]));
            fire = en && !fl && (int'(req) <= avail_q.size());
            tick();

            for (int j = 0; j < k; j++) begin
                avail_q.push_back(arch_q.pop_front());
                arch_q.push_back(spec_q.pop_front());
            end
            if (fire) begin
                for (int j = 0; j < int'(req); j++) spec_q.push_back(avail_q.pop_front());
            end
            if (fl) begin
                for (int j = spec_q.size() - 1; j >= 0; j--) avail_q.push_front(spec_q[j]);
                spec_q.delete();
            end
        end
        idle();
        #1;
        checkOutput("final_count", 32'(bus.free_count), 32'(avail_q.size()));
        checkOutput("final_error", 32'(bus.error), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/preg_free_list.md
Name: preg_free_list

Overview:
- Physical-register allocator directly upstream of the issue/commit stage. It supplies the `preg1`/`preg2` destination tags that stage writes into the ROB and RAT.
- Holds unallocated physical registers in a circular FIFO. Hands out up to 2 per cycle and accepts up to 2 released registers per cycle from commit.
- Tracks a committed head pointer so a pipeline flush (mispredict/exception) returns all speculatively allocated registers in one cycle.

Parameters:
- NUM_PREGS, 64, physical register count; must be a power of 2.
- NUM_AREGS, 32, architectural register count; must be less than NUM_PREGS.
- PREG_BITS, $clog2(NUM_PREGS), tag width.
- FREE_INIT, NUM_PREGS-NUM_AREGS, free entries after reset or flush.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enabled  in  1  rename stage advancing this cycle.
- alloc_req  in  2  registers wanted this cycle (0..2); same encoding as num_execute.
- alloc_stall  out  1  alloc_req exceeds free_count.
- preg1  out  PREG_BITS  tag for first instruction.
- preg2  out  PREG_BITS  tag for second instruction.
- free_valid  in  2  bit0 = free_preg1 valid, bit1 = free_preg2 valid.
- free_preg1  in  PREG_BITS  released tag (old mapping of committed instruction).
- free_preg2  in  PREG_BITS  second released tag.
- commit_count  in  2  instructions that committed and had allocated a register this cycle.
- flush  in  1  discard all speculative allocations.
- free_count  out  PREG_BITS+1  current free entries.
- error  out  1  sticky overflow/underflow flag.

Behaviour:
- Storage:
  - list[NUM_PREGS] of PREG_BITS.
  - Pointers head, tail and commit_head, each PREG_BITS wide; they wrap naturally mod NUM_PREGS.
  - Register count, PREG_BITS+1 wide.
- Reset (asynchronous, reset low):
  - list[i] = NUM_AREGS+i for i < FREE_INIT; remaining entries 0.
  - head = 0, commit_head = 0, tail = FREE_INIT mod NUM_PREGS, count = FREE_INIT, error = 0.
  - Architectural register i maps to preg i at reset.
- Outputs (combinational):
  - preg1 = list[head], preg2 = list[head+1], free_count = count.
  - alloc_stall = (alloc_req > count). It never depends on frees arriving in the same cycle.
- Allocate:
  - alloc_fire = enabled && !alloc_stall && !flush.
  - On alloc_fire: head <= head + alloc_req.
  - alloc_req == 1 consumes only preg1. alloc_req == 0 is a no-op.
- Release:
  - Valid free tags are compacted and written at tail, then tail+1.
  - If only bit1 is valid, free_preg2 is written at tail.
  - tail <= tail + popcount(free_valid).
  - A freed register becomes visible to allocation no earlier than the next cycle.
- Commit tracking: commit_head <= commit_head + commit_count every cycle, including flush cycles.
- Count update:
  - Normal cycle: count <= count - (alloc_fire ? alloc_req : 0) + popcount(free_valid).
  - Flush cycle: head <= commit_head + commit_count and count <= FREE_INIT. Frees in that cycle are still written to tail.
  - Invariant: in-flight speculative registers are exactly those between commit_head and head.
- Simultaneous allocate + free: both apply, and the count arithmetic nets them.
  - Example: count = 0 with 2 frees gives stall this cycle and count = 2 next cycle.
- Error (sticky until reset):
  - Set if next count would exceed FREE_INIT.
  - Set if alloc_fire occurs while enabled and alloc_req > count (cannot happen; checked by assertion).
  - Set if commit_count advances commit_head past head.
- Reset mid-operation overrides everything within the same cycle.

Decomposition:
- Shared package (defines.inc): NUM_PREGS, NUM_AREGS, PREG_BITS.
- No new typedefs needed.
- One natural sub-module: free_list_ram, a NUM_PREGS × PREG_BITS storage with 2 write ports and 2 asynchronous read ports, with reset initialisation. Pointer and count logic stays in preg_free_list.

Test Plan:
- Reset then idle → preg1 = 32, preg2 = 33, free_count = 32, alloc_stall = 0, error = 0.
- Sixteen cycles of alloc_req = 2 with enabled → free_count = 0. The seventeenth request (alloc_req = 1) → alloc_stall = 1 and head unchanged.
- count = 0, free_valid = 2'b11 with tags 5 and 7, alloc_req = 2 → stall this cycle. Next cycle preg1 = 5, preg2 = 7, alloc_stall = 0.
- Allocate 6 (tags 32..37), commit_count = 1 twice, then flush → free_count = 32 and preg1 = 34.
- free_valid = 2'b10 with free_preg2 = 9 when count = 31 → tag 9 stored at old tail and free_count = 32. A further free from a count of 32 → error = 1.
- Assert reset low while alloc_req = 2 is firing → all outputs immediately return to reset values, with preg1 = 32 after reset release.
